// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampled UART receiver with start validation and framing check
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   tick         baud x OVERSAMPLE strobe, one clk wide (may be held high)
//   rx           asynchronous serial line, idle high
//   o_data       last correctly received byte (DATA_BITS wide)
//   o_rx_done    one-cycle pulse: o_data holds a new valid byte
//   o_frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   o_busy       high whenever the receiver is not idle

module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_d1, rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;

    logic tick_mid, tick_end, bit_last;
    logic done_set, err_set;

    assign tick_mid = (tick_cnt == T_MID);
    assign tick_end = (tick_cnt == T_END);
    assign bit_last = (bit_cnt == B_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                // A line that is high again at mid-start was a glitch.
                if (tick && tick_mid) state_nxt = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && tick_end && bit_last) state_nxt = S_STOP;
            end
            S_STOP: begin
                // Leave at mid-stop so a following start edge half a bit
                // later is still seen from IDLE.
                if (tick && tick_end) state_nxt = rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                // Hold off until the line returns high so a long break is
                // not decoded as a stream of zero bytes.
                if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_busy   = (state != S_IDLE);
        done_set = 1'b0;
        err_set  = 1'b0;
        if (state == S_STOP && tick && tick_end) begin
            done_set = rx_s;
            err_set  = !rx_s;
        end
    end

    // Synchroniser, counters, shift register and registered pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_d1       <= 1'b1;
            rx_s        <= 1'b1;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_d1       <= rx;
            rx_s        <= rx_d1;
            o_rx_done   <= done_set;
            o_frame_err <= err_set;
            if (done_set) o_data <= shift;

            case (state)
                S_IDLE: begin
                    if (!rx_s) tick_cnt <= '0;
                end
                S_START: begin
                    if (tick) begin
                        if (tick_mid) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (tick_end) begin
                            shift    <= {rx_s, shift[DATA_BITS-1:1]};
                            tick_cnt <= '0;
                            if (!bit_last) bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (tick_end) tick_cnt <= '0;
                        else          tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampled UART receiver: the downstream consumer of the serial line driven by the team's UART transmitter.
- Shares the same baud-tick strobe as the transmitter.
- Synchronises the asynchronous rx line, detects and validates the start bit, and samples LSB-first data bits at mid-bit.
- Checks the stop bit, then presents the byte with a one-cycle done pulse, or flags a framing error, toward the APB UART register block.

Parameters:
DATA_BITS, 8, data bits per frame (5..8), LSB first
OVERSAMPLE, 16, ticks per bit period; must be even

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
tick  input  1  baud x OVERSAMPLE strobe, one clk wide
rx  input  1  asynchronous serial line, idle high
o_data  output  DATA_BITS  last correctly received byte
o_rx_done  output  1  one-cycle pulse: o_data updated with a new valid byte
o_frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values:
  - o_data=0, o_rx_done=0, o_frame_err=0, o_busy=0.
  - Both synchroniser flops =1; tick_cnt=0, bit_cnt=0, shift register=0; state=IDLE.
- Synchroniser: rx passes through 2 flops -> rx_s. All decisions use rx_s only.
- Counters: tick_cnt is $clog2(OVERSAMPLE) bits wide; bit_cnt is 3 bits. tick_cnt advances only on clk edges where tick=1.
- IDLE:
  - On rx_s==0 (tick not required): go to START, tick_cnt=0.
- START:
  - On tick with tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rx_s==0 -> go to DATA, tick_cnt=0, bit_cnt=0.
    - rx_s==1 -> false start; return to IDLE, no output pulse.
  - Otherwise, on tick: tick_cnt+1.
- DATA:
  - On tick with tick_cnt==OVERSAMPLE-1: shift=={rx_s, shift[DATA_BITS-1:1]}, tick_cnt=0.
    - If bit_cnt==DATA_BITS-1 -> go to STOP; else bit_cnt+1.
  - Otherwise, on tick: tick_cnt+1.
- STOP:
  - On tick with tick_cnt==OVERSAMPLE-1 (mid stop bit), tick_cnt=0, then:
    - rx_s==1 -> o_data<=shift, o_rx_done=1 for exactly the next clk cycle, go to IDLE.
    - rx_s==0 -> o_frame_err=1 for exactly the next clk cycle, o_data unchanged, go to BREAK.
- BREAK:
  - Wait until rx_s==1, then go to IDLE. Prevents a held-low line from being re-read as endless 0x00 frames.
- Latency:
  - Line falling edge to START entry: 3 clk (2 sync + 1 state).
  - Done/err pulse: asserted in the clk cycle after the mid-stop sampling tick.
- o_data is held until the next valid frame; it is never cleared by a frame error.
- Back-to-back frames:
  - Detection returns to IDLE at mid-stop. A start edge arriving half a bit later must be caught.
  - A transmitter running 16 ticks per stop bit therefore never loses a frame.
- tick held high continuously (test mode) is legal; each clk counts as one tick.
- Reset mid-frame: immediate return to IDLE with all reset values; no pulse is generated for the partial frame.
- o_rx_done and o_frame_err are never high in the same cycle.

Test Plan:
- Bench setup for all cases: tick every 4 clk (one bit period = 64 clk), 8N1 frames, rx driven per frame.
- Frame 0x55, then 0xA3, each with an idle gap -> o_rx_done pulses exactly twice, 1 clk each; o_data=0x55 then 0xA3; o_frame_err stays 0.
- rx low for 3 ticks (12 clk) then high -> START aborts at mid-start; o_busy returns to 0; no pulse; o_data unchanged.
- Frame 0x3C with stop bit driven 0, line held low 5 bit periods, then high, then valid frame 0x81 -> one o_frame_err pulse; o_data stays previous; no frames during the low hold; then o_rx_done with o_data=0x81.
- Three frames 0x00, 0xFF, 0x7E with exactly 1 stop bit between them -> three o_rx_done pulses with matching o_data in order; no framing errors.
- rst asserted mid-DATA (after 4 data bits), released, then frame 0xC5 -> outputs at reset values immediately; no pulse for the aborted frame; 0xC5 received correctly.
- Transmitter instance looped back into rx with shared tick, bytes 0x00..0xFF -> every byte received in order; zero framing errors.
